// File: rtl/fp32_adder_arbiter.sv
// fp32_adder_arbiter: shares one external fp32 adder between N requesters.
//
// A round-robin arbiter grants one requester at a time, hands its operand pair
// to the adder, collects the sum and returns it to that requester. Exactly one
// operation is in flight; the FSM runs Idle -> Issue -> WaitRes -> Ack ->
// Deliver -> Idle.
//
// Optional build macro FP32_ARB_WATCHDOG_EN: adds a WaitRes cycle counter; if
// the adder stays silent for TIMEOUT_CYCLES cycles a quiet NaN is delivered
// with res_err_o set. Without the macro WaitRes waits forever and res_err_o
// is tied low.
//
// Ports:
//   clk, srst               clock, synchronous active-high reset
//   req_valid_i/req_ready_o per-requester operand handshake (ready = grant)
//   req_a_i/req_b_i         packed operands, requester i at [32i+31:32i]
//   res_valid_o/res_ack_i   per-requester result handshake
//   res_z_o, res_err_o      shared result sum, watchdog-substitute flag
//   add_valid_stb_o/add_ready_i, add_a_o/add_b_o   operand side of the adder
//   add_valid_stb_i/add_ack_z_o, add_z_i           result side of the adder
module fp32_adder_arbiter #(
    parameter int unsigned N              = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            srst,
    input  logic [N-1:0]    req_valid_i,
    output logic [N-1:0]    req_ready_o,
    input  logic [N*32-1:0] req_a_i,
    input  logic [N*32-1:0] req_b_i,
    output logic [N-1:0]    res_valid_o,
    output logic [31:0]     res_z_o,
    output logic            res_err_o,
    input  logic [N-1:0]    res_ack_i,
    output logic            add_valid_stb_o,
    input  logic            add_ready_i,
    output logic [31:0]     add_a_o,
    output logic [31:0]     add_b_o,
    input  logic            add_valid_stb_i,
    input  logic [31:0]     add_z_i,
    output logic            add_ack_z_o
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StIssue   = 3'd1;
    localparam logic [2:0] StWaitRes = 3'd2;
    localparam logic [2:0] StAck     = 3'd3;
    localparam logic [2:0] StDeliver = 3'd4;

    if (N < 2 || N > 8) begin : g_bad_n
        $error("fp32_adder_arbiter: N must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fp32_adder_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] gnt_q, gnt_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     z_q, z_d;

`ifdef FP32_ARB_WATCHDOG_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // Round-robin search starting at ptr_q; cand carries one extra bit so the
    // wrap past N-1 can be undone with a single subtract.
    logic            win_found;
    logic [IdxW-1:0] win_idx;
    logic [IdxW:0]   cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IdxW+1)'(k);
            if (cand >= (IdxW+1)'(N)) begin
                cand = cand - (IdxW+1)'(N);
            end
            if (!win_found && req_valid_i[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxW-1:0];
            end
        end
    end

    logic grant;
    assign grant = (state_q == StIdle) && add_ready_i && win_found;

    always_comb begin
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        res_valid_o = '0;
        if (state_q == StDeliver) begin
            res_valid_o[gnt_q] = 1'b1;
        end
    end

    assign add_valid_stb_o = (state_q == StIssue);
    assign add_ack_z_o     = (state_q == StAck);
    assign add_a_o         = a_q;
    assign add_b_o         = b_q;
    assign res_z_o         = z_q;

`ifdef FP32_ARB_WATCHDOG_EN
    assign res_err_o = err_q;
`else
    assign res_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
`ifdef FP32_ARB_WATCHDOG_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (grant) begin
                    gnt_d   = win_idx;
                    a_d     = req_a_i[{win_idx, 5'b0} +: 32];
                    b_d     = req_b_i[{win_idx, 5'b0} +: 32];
                    ptr_d   = (win_idx == IdxW'(N - 1)) ? '0 : win_idx + IdxW'(1);
                    state_d = StIssue;
                end
            end
            StIssue: begin
`ifdef FP32_ARB_WATCHDOG_EN
                cnt_d   = '0;
`endif
                state_d = StWaitRes;
            end
            StWaitRes: begin
                if (add_valid_stb_i) begin
                    z_d     = add_z_i;
                    state_d = StAck;
                end
`ifdef FP32_ARB_WATCHDOG_EN
                // Counter holds the number of silent WaitRes cycles already
                // spent; this is the last one allowed.
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    z_d     = 32'h7FC0_0000;
                    err_d   = 1'b1;
                    state_d = StDeliver;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StAck: begin
                state_d = StDeliver;
            end
            StDeliver: begin
                if (res_ack_i[gnt_q]) begin
`ifdef FP32_ARB_WATCHDOG_EN
                    err_d   = 1'b0;
`endif
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
`ifdef FP32_ARB_WATCHDOG_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
`ifdef FP32_ARB_WATCHDOG_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: doc/fp32_adder_arbiter.md
FP32_ADDER_ARBITER -- requirements
Module: fp32_adder_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one fp32 adder, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: watchdog limit, used only when the Configuration macro is defined.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 srst  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  N  requester i has an operand pair pending.
REQ-006 req_ready_o  output  N  operands of requester i accepted this cycle.
REQ-007 req_a_i  input  N*32  operand A; requester i uses bits [32i+31:32i].
REQ-008 req_b_i  input  N*32  operand B; same packing as req_a_i.
REQ-009 res_valid_o  output  N  result available to requester i.
REQ-010 res_z_o  output  32  result sum, shared by all requesters.
REQ-011 res_err_o  output  1  result is a watchdog substitute.
REQ-012 res_ack_i  input  N  requester i consumes its result.
REQ-013 add_valid_stb_o  output  1  operand strobe to the adder.
REQ-014 add_ready_i  input  1  adder is idle.
REQ-015 add_a_o  output  32  operand A to the adder.
REQ-016 add_b_o  output  32  operand B to the adder.
REQ-017 add_valid_stb_i  input  1  adder result is valid; held by the adder until acknowledged.
REQ-018 add_z_i  input  32  adder result.
REQ-019 add_ack_z_o  output  1  result acknowledge to the adder.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT_RES, ACK and DELIVER, with at most one operation in flight.
REQ-021 In IDLE with add_ready_i=1 and any req_valid_i set, the block SHALL select winner g by round-robin starting at index ptr.
- It SHALL drive req_ready_o[g]=1 combinationally for that cycle only.
- It SHALL register g, req_a_i[g] and req_b_i[g].
- It SHALL set ptr to (g+1) mod N.
- The next state SHALL be ISSUE.
REQ-022 In IDLE with add_ready_i=0, or with no request pending, req_ready_o SHALL be all-zero and the FSM SHALL stay in IDLE.
REQ-023 In ISSUE, add_valid_stb_o SHALL be 1 for exactly one cycle, add_a_o/add_b_o SHALL carry the latched operands, and the next state SHALL be WAIT_RES.
REQ-024 add_a_o/add_b_o SHALL hold the latched operands from ISSUE until the next grant.
REQ-025 In WAIT_RES, when add_valid_stb_i=1 the block SHALL capture add_z_i and go to ACK.
REQ-026 In ACK, add_ack_z_o SHALL be 1 for exactly one cycle, and the next state SHALL be DELIVER.
REQ-027 In DELIVER, res_valid_o SHALL be one-hot at bit g and res_z_o SHALL hold the captured sum.
- They SHALL remain stable until res_ack_i[g]=1, then the FSM SHALL return to IDLE.
- res_ack_i bits other than g SHALL be ignored.
REQ-028 Latency from grant to res_valid_o SHALL be 3 cycles plus the adder latency; the minimum request-to-request spacing SHALL be 5 cycles.
REQ-029 The requester with index ptr SHALL have highest priority, so a requester asserting continuously waits at most N-1 grants.
REQ-030 req_valid_i dropping in a cycle where the requester is not granted SHALL be legal; no state SHALL be affected.

Reset
REQ-031 With srst=1, the next clock edge SHALL force the following, regardless of state, including mid-operation:
- state=IDLE and ptr=0;
- res_valid_o=0, res_z_o=0, res_err_o=0;
- add_valid_stb_o=0, add_ack_z_o=0, add_a_o=0, add_b_o=0.
REQ-032 A reset during WAIT_RES SHALL discard the in-flight result; the adder is reset by the same srst.

Configuration
REQ-033 Macro FP32_ARB_WATCHDOG_EN, when defined, SHALL add a WAIT_RES cycle counter that is cleared on entering WAIT_RES.
- If the counter reaches TIMEOUT_CYCLES without add_valid_stb_i, the block SHALL load res_z_o=32'h7FC0_0000, set res_err_o=1, skip ACK and go to DELIVER.
- res_err_o SHALL clear on leaving DELIVER.
REQ-034 Without FP32_ARB_WATCHDOG_EN, there SHALL be no counter, WAIT_RES SHALL wait indefinitely, and res_err_o SHALL be tied to 0.

Verification
REQ-035 Single request: requester 0 sends 32'h3F80_0000 + 32'h4000_0000 -> res_valid_o=4'b0001, res_z_o=32'h4040_0000, one add_ack_z_o pulse.
REQ-036 All requesters asserted from reset, each carrying operands 1.0 + i:
- grants SHALL occur in order 0,1,2,3,0;
- each result SHALL match its requester: 32'h3F80_0000+32'h0000_0000 -> 32'h3F80_0000 for requester 0, and 32'h3F80_0000+32'h3F80_0000 -> 32'h4000_0000 for requester 1.
REQ-037 Result backpressure: res_ack_i held 0 for 20 cycles -> res_valid_o and res_z_o SHALL be stable and req_ready_o SHALL be 0 throughout.
REQ-038 Reset mid-operation: srst pulsed during WAIT_RES -> all outputs zero next cycle; a following request 0+0 SHALL return 32'h0000_0000.
REQ-039 Watchdog (with FP32_ARB_WATCHDOG_EN, adder model that never responds, TIMEOUT_CYCLES=64) -> after 64 cycles in WAIT_RES, res_z_o=32'h7FC0_0000 and res_err_o=1.
REQ-040 NaN passthrough: operands 32'hFFFF_FFFF + 32'hFFFF_FFFF -> res_z_o=32'hFFC0_0000, res_err_o=0.
